// File: rtl/pif_led_ctl_pkg.sv
// Shared definitions for the multi-channel LED pattern controller.
// Holds the LED mode encoding, the register select values and the
// address-width helper used by pif_led_ctl and pif_led_pwm.
package pif_led_ctl_pkg;

    // Per-channel pattern mode, stored in ctrl[1:0]
    typedef enum logic [1:0] {
        LED_MODE_OFF     = 2'd0,
        LED_MODE_ON      = 2'd1,
        LED_MODE_FLASH   = 2'd2,
        LED_MODE_BREATHE = 2'd3
    } led_mode_e;

    // Low address bit selects the register inside a channel
    localparam logic LED_SEL_CTRL = 1'b0;
    localparam logic LED_SEL_DUTY = 1'b1;

    // Implemented ctrl bits; anything above reads back as zero
    localparam int CTRL_BITS = 3;

    // ctrl register layout: [2] inv, [1:0] mode
    typedef struct packed {
        logic      inv;
        led_mode_e mode;
    } led_ctrl_t;

    // Channel field width; a single channel still gets one address bit
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pif_led_pwm.sv
// One LED channel: picks the brightness level for the channel's mode and
// compares it against the shared PWM counter. The LED bit is registered,
// so it lags the counter value it was derived from by one cycle.
module pif_led_pwm
    import pif_led_ctl_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  led_mode_e           mode,
    input  logic                inv,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] ramp,
    input  logic                flash_ph,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    logic [PWM_BITS-1:0] level_p0;
    logic                lit_p0;

    // Brightness level for the current mode; full scale is treated as
    // always-lit so the LED never blinks dark at the counter wrap
    always_comb begin
        level_p0 = '0;
        case (mode)
            LED_MODE_OFF:     level_p0 = '0;
            LED_MODE_ON:      level_p0 = duty;
            LED_MODE_FLASH:   level_p0 = (flash_ph ^ inv) ? duty : '0;
            LED_MODE_BREATHE: level_p0 = inv ? ~ramp : ramp;
            default:          level_p0 = '0;
        endcase
        lit_p0 = (level_p0 == LEVEL_MAX) | (pwm_cnt < level_p0);
    end

    // stage p0 -> registered LED drive
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= lit_p0;
        end
    end

endmodule

// File: rtl/pif_led_ctl.sv
// Multi-channel LED pattern controller (OFF / ON / FLASH / BREATHE per LED
// with PWM brightness). Holds the register file, the shared PWM counter,
// the flash and breathe prescalers and the shared breathe ramp; one
// pif_led_pwm per channel produces the LED bit.
// Build option: define PIF_LED_BREATHE_EN to build the breathe prescaler
// and ramp. Without it mode 3 drives the LED exactly like FLASH, while the
// ctrl register still stores and returns 3.
module pif_led_ctl
    import pif_led_ctl_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  PWM_BITS    = 8,
    parameter int  FLASH_DIV   = 6000000,
    parameter int  BREATHE_DIV = 23437,
    localparam int CH_BITS     = ch_bits(NUM_CH)
) (
    input  logic                xclk,
    input  logic                sys_rst,
    input  logic                wr_en,
    input  logic [CH_BITS:0]    wr_addr,
    input  logic [PWM_BITS-1:0] wr_data,
    input  logic [CH_BITS:0]    rd_addr,
    output logic [PWM_BITS-1:0] rd_data,
    output logic [NUM_CH-1:0]   led
);

    // Both prescalers share one counter width sized for the larger divider
    localparam int PRE_DIV_MAX = (FLASH_DIV > BREATHE_DIV) ? FLASH_DIV : BREATHE_DIV;
    localparam int PRE_W       = $clog2(PRE_DIV_MAX);

    led_ctrl_t           ctrl_q [NUM_CH];
    logic [PWM_BITS-1:0] duty_q [NUM_CH];

    logic [CH_BITS-1:0]  wr_ch;
    logic                wr_sel;
    logic [CH_BITS-1:0]  rd_ch;
    logic                rd_sel;
    logic [PWM_BITS-1:0] rd_mux;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    fl_cnt;
    logic                flash_tick;
    logic                flash_ph;
    logic [PWM_BITS-1:0] ramp;

    assign {wr_ch, wr_sel} = wr_addr;
    assign {rd_ch, rd_sel} = rd_addr;

    // Register file; a channel field beyond NUM_CH matches nothing
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctrl_q[i] <= '0;
                duty_q[i] <= '1;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch == CH_BITS'(i)) begin
                    if (wr_sel == LED_SEL_DUTY) begin
                        duty_q[i] <= wr_data;
                    end else begin
                        ctrl_q[i] <= led_ctrl_t'(wr_data[CTRL_BITS-1:0]);
                    end
                end
            end
        end
    end

    // Read mux; unmapped channels and unused ctrl bits read as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_BITS'(i)) begin
                rd_mux = (rd_sel == LED_SEL_DUTY) ? duty_q[i] : PWM_BITS'(ctrl_q[i]);
            end
        end
    end

    // stage p0 -> registered read data (one-cycle read latency)
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

    // Free-running PWM counter shared by every channel
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    assign flash_tick = (fl_cnt == PRE_W'(FLASH_DIV - 1));

    // Flash prescaler; the phase flips once per half-period
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            fl_cnt   <= '0;
            flash_ph <= 1'b0;
        end else begin
            fl_cnt <= flash_tick ? '0 : fl_cnt + PRE_W'(1);
            if (flash_tick) begin
                flash_ph <= ~flash_ph;
            end
        end
    end

`ifdef PIF_LED_BREATHE_EN
    localparam logic [PWM_BITS-1:0] RAMP_TOP_M1 = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [PRE_W-1:0] br_cnt;
    logic             br_tick;
    logic             ramp_dn;

    assign br_tick = (br_cnt == PRE_W'(BREATHE_DIV - 1));

    // Breathe prescaler and triangle ramp; direction flips on the step that
    // reaches an end so each end value is held for a single step
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            br_cnt  <= '0;
            ramp    <= '0;
            ramp_dn <= 1'b0;
        end else begin
            br_cnt <= br_tick ? '0 : br_cnt + PRE_W'(1);
            if (br_tick) begin
                if (!ramp_dn) begin
                    ramp <= ramp + PWM_BITS'(1);
                    if (ramp == RAMP_TOP_M1) begin
                        ramp_dn <= 1'b1;
                    end
                end else begin
                    ramp <= ramp - PWM_BITS'(1);
                    if (ramp == PWM_BITS'(1)) begin
                        ramp_dn <= 1'b0;
                    end
                end
            end
        end
    end
`else
    assign ramp = '0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        led_mode_e eff_mode;

`ifdef PIF_LED_BREATHE_EN
        assign eff_mode = ctrl_q[c].mode;
`else
        assign eff_mode = (ctrl_q[c].mode == LED_MODE_BREATHE) ? LED_MODE_FLASH
                                                               : ctrl_q[c].mode;
`endif

        pif_led_pwm #(
            .PWM_BITS (PWM_BITS)
        ) u_pwm (
            .clk      (xclk),
            .rst      (sys_rst),
            .mode     (eff_mode),
            .inv      (ctrl_q[c].inv),
            .duty     (duty_q[c]),
            .ramp     (ramp),
            .flash_ph (flash_ph),
            .pwm_cnt  (pwm_cnt),
            .led      (led[c])
        );
    end

endmodule

// File: tb/tb_pif_led_ctl.sv
// Self-checking bench for pif_led_ctl (PWM_BITS=4, FLASH_DIV=8,
// BREATHE_DIV=2). Three channels so the two-bit channel field has an
// unmapped value (3). The reference model derives counters, flash phase
// and breathe ramp directly from the number of cycles since reset.
module tb_pif_led_ctl;

    localparam int NC     = 3;
    localparam int PB     = 4;
    localparam int FL_DIV = 8;
    localparam int BR_DIV = 2;
    localparam int CHB    = 2;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [CHB:0]  wr_addr = '0;
    logic [PB-1:0] wr_data = '0;
    logic [CHB:0]  rd_addr = '0;
    logic [PB-1:0] rd_data;
    logic [NC-1:0] led;

    int tests = 0;
    int fails = 0;

    // model state
    logic [2:0]    sh_ctrl [NC];
    logic [PB-1:0] sh_duty [NC];
    int            n = 0;

    pif_led_ctl #(
        .NUM_CH      (NC),
        .PWM_BITS    (PB),
        .FLASH_DIV   (FL_DIV),
        .BREATHE_DIV (BR_DIV)
    ) dut (
        .xclk    (clk),
        .sys_rst (sys_rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .led     (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, n);
        end
    endtask

    // triangle 0..15..1 with period 30 ramp steps
    function automatic logic [PB-1:0] tri_ramp(input int cyc);
        int p;
        p = (cyc / BR_DIV) % 30;
        return (p <= 15) ? PB'(p) : PB'(30 - p);
    endfunction

    function automatic logic exp_lit(input int ch, input int cyc);
        logic [1:0]    mode;
        logic          inv;
        logic          ph;
        logic [PB-1:0] lvl;
        mode = sh_ctrl[ch][1:0];
        inv  = sh_ctrl[ch][2];
        ph   = ((cyc / FL_DIV) % 2) == 1;
`ifndef PIF_LED_BREATHE_EN
        if (mode == 2'd3) mode = 2'd2;
`endif
        case (mode)
            2'd1:    lvl = sh_duty[ch];
            2'd2:    lvl = (ph ^ inv) ? sh_duty[ch] : 4'h0;
            2'd3:    lvl = inv ? PB'(15 - int'(tri_ramp(cyc))) : tri_ramp(cyc);
            default: lvl = 4'h0;
        endcase
        return (lvl == 4'hF) || (PB'(cyc % 16) < lvl);
    endfunction

    function automatic logic [PB-1:0] exp_read(input logic [CHB:0] a);
        int ch;
        ch = int'(a[CHB:1]);
        if (ch >= NC) return '0;
        return a[0] ? sh_duty[ch] : {1'b0, sh_ctrl[ch]};
    endfunction

    // one clock: predict, advance model, then compare led and rd_data
    task automatic step();
        logic [NC-1:0] e_led;
        logic [PB-1:0] e_rd;
        int            ch;
        e_led = '0;
        e_rd  = '0;
        if (!sys_rst) begin
            for (int c = 0; c < NC; c++) e_led[c] = exp_lit(c, n);
            e_rd = exp_read(rd_addr);
        end
        if (sys_rst) begin
            for (int c = 0; c < NC; c++) begin
                sh_ctrl[c] = 3'd0;
                sh_duty[c] = 4'hF;
            end
            n = 0;
        end else begin
            ch = int'(wr_addr[CHB:1]);
            if (wr_en && ch < NC) begin
                if (wr_addr[0]) sh_duty[ch] = wr_data;
                else            sh_ctrl[ch] = wr_data[2:0];
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("led", 32'(led), 32'(e_led));
        check("rd_data", 32'(rd_data), 32'(e_rd));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wr(input int ch, input logic sel, input logic [PB-1:0] d);
        wr_en   = 1'b1;
        wr_addr = {CHB'(ch), sel};
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic count_on(input string tag, input int want);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            cnt += int'(led[0]);
        end
        check(tag, 32'(cnt), 32'(want));
    endtask

    initial begin
        // reset and idle
        run(3);
        check("reset_led", 32'(led), 32'd0);
        check("reset_rd", 32'(rd_data), 32'd0);
        sys_rst = 1'b0;
        run(64);
        check("idle_led", 32'(led), 32'd0);
        rd_addr = {2'd1, 1'b1};
        run(2);
        check("duty1_reset", 32'(rd_data), 32'hF);

        // ON with several duties
        wr(0, 1'b0, 4'd1);
        wr(0, 1'b1, 4'd4);
        run(3);
        count_on("on_duty4", 4);
        wr(0, 1'b1, 4'd15);
        run(2);
        count_on("on_duty15", 16);
        wr(0, 1'b1, 4'd0);
        run(2);
        count_on("on_duty0", 0);

        // FLASH in antiphase
        wr(0, 1'b0, 4'd2);
        wr(1, 1'b0, 4'd6);
        wr(0, 1'b1, 4'd15);
        wr(1, 1'b1, 4'd15);
        begin
            int both, toggles;
            logic prev;
            both    = 0;
            toggles = 0;
            step();
            prev = led[0];
            for (int i = 0; i < 64; i++) begin
                step();
                if (led[0] && led[1]) both++;
                if (led[0] != prev) toggles++;
                prev = led[0];
            end
            check("flash_both_lit", 32'(both), 32'd0);
            check("flash_toggles", 32'(toggles), 32'd8);
        end

        // BREATHE (FLASH when the feature is not built), both polarities
        wr(0, 1'b0, 4'd3);
        wr(2, 1'b0, 4'd7);
        run(160);

        // unmapped channel: writes dropped, reads zero
        rd_addr = {2'd3, 1'b0};
        wr(3, 1'b0, 4'd5);
        wr(3, 1'b1, 4'd9);
        run(1);
        check("unmapped_rd", 32'(rd_data), 32'd0);
        rd_addr = {2'd1, 1'b0};
        run(2);
        check("ctrl1_kept", 32'(rd_data), 32'd6);

        // same-cycle write and read of duty0
        wr(0, 1'b1, 4'd7);
        rd_addr = {2'd0, 1'b1};
        run(1);
        wr(0, 1'b1, 4'd9);
        check("rd_old", 32'(rd_data), 32'd7);
        run(1);
        check("rd_new", 32'(rd_data), 32'd9);

        // reset mid-FLASH with a write pending
        wr(0, 1'b0, 4'd2);
        run(11);
        sys_rst = 1'b1;
        wr_en   = 1'b1;
        wr_addr = {2'd0, 1'b1};
        wr_data = 4'd3;
        step();
        check("rst_led", 32'(led), 32'd0);
        sys_rst = 1'b0;
        wr_en   = 1'b0;
        rd_addr = {2'd0, 1'b0};
        run(1);
        check("rst_ctrl0", 32'(rd_data), 32'd0);
        rd_addr = {2'd0, 1'b1};
        run(1);
        check("rst_duty0", 32'(rd_data), 32'hF);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            sys_rst = ($urandom_range(0, 599) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom);
            wr_data = 4'($urandom);
            rd_addr = 3'($urandom);
            step();
        end
        sys_rst = 1'b0;
        wr_en   = 1'b0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
